cc_alu_mul_sequencer: RTL



---
 rtl/cc_alu_mul_sequencer.sv | 130 +++++++++++++
 1 files changed

// File: rtl/cc_alu_mul_sequencer.sv
// cc_alu_mul_sequencer: unsigned shift-add multiplier that borrows the
// datapath ALU as its only adder and retires one multiplier bit per clock.
// Optional build macro: CC_ALUSEQ_ZERO_SHORTCUT_EN -- when defined, a zero
// operand at start acceptance completes immediately with product 0 and
// never enters RUN.
module cc_alu_mul_sequencer #(
    parameter int DATAWIDTH_BUS           = 32,
    parameter int DATAWIDTH_ALU_SELECTION = 4
) (
    input  logic                               CC_ALUSEQ_CLOCK_50,
    input  logic                               CC_ALUSEQ_RESET_InHigh,
    input  logic                               CC_ALUSEQ_start_In,
    input  logic [DATAWIDTH_BUS-1:0]           CC_ALUSEQ_multiplicand_InBus,
    input  logic [DATAWIDTH_BUS-1:0]           CC_ALUSEQ_multiplier_InBus,
    output logic                               CC_ALUSEQ_busy_Out,
    output logic                               CC_ALUSEQ_done_Out,
    output logic [2*DATAWIDTH_BUS-1:0]         CC_ALUSEQ_product_OutBus,
    output logic [DATAWIDTH_BUS-1:0]           CC_ALUSEQ_aluDataA_OutBus,
    output logic [DATAWIDTH_BUS-1:0]           CC_ALUSEQ_aluDataB_OutBus,
    output logic [DATAWIDTH_ALU_SELECTION-1:0] CC_ALUSEQ_aluSelection_OutBus,
    input  logic [DATAWIDTH_BUS-1:0]           CC_ALUSEQ_aluData_InBus,
    input  logic                               CC_ALUSEQ_aluCarry_InLow
);
    localparam int W  = DATAWIDTH_BUS;
    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam logic [DATAWIDTH_ALU_SELECTION-1:0] SEL_PASSA = '0;
    localparam logic [DATAWIDTH_ALU_SELECTION-1:0] SEL_ADD   = DATAWIDTH_ALU_SELECTION'(4'b1000);

    typedef enum logic {IDLE, RUN} state_t;

    state_t          state, stateNext;
    logic [W-1:0]    hiReg, loReg, mReg;
    logic [CW-1:0]   cnt;
    logic            carryIn;
    logic            accept;
    logic            zeroOp;
    logic            lastIter;
    logic [DATAWIDTH_ALU_SELECTION-1:0] aluSel;

`ifdef CC_ALUSEQ_ZERO_SHORTCUT_EN
    assign zeroOp = (CC_ALUSEQ_multiplicand_InBus == '0) || (CC_ALUSEQ_multiplier_InBus == '0);
`else
    assign zeroOp = 1'b0;
`endif

    assign lastIter = (cnt == CW'(W - 1));

    // HI feeds ALU operand A and the captured multiplicand feeds operand B;
    // both sit at zero while idle because completion clears them.
    assign CC_ALUSEQ_aluDataA_OutBus     = hiReg;
    assign CC_ALUSEQ_aluDataB_OutBus     = mReg;
    assign CC_ALUSEQ_aluSelection_OutBus = aluSel;

    // State register
    always_ff @(posedge CC_ALUSEQ_CLOCK_50) begin
        if (CC_ALUSEQ_RESET_InHigh) state <= IDLE;
        else                        state <= stateNext;
    end

    // Next state, ALU opcode and the gated carry into the shift
    always_comb begin
        stateNext = state;
        aluSel    = SEL_PASSA;
        accept    = 1'b0;
        carryIn   = 1'b0;
        case (state)
            IDLE: begin
                if (CC_ALUSEQ_start_In) begin
                    accept = 1'b1;
                    if (!zeroOp) stateNext = RUN;
                end
            end
            RUN: begin
                // Carry is meaningful only when an ADD was actually issued.
                aluSel  = loReg[0] ? SEL_ADD : SEL_PASSA;
                carryIn = loReg[0] & ~CC_ALUSEQ_aluCarry_InLow;
                if (lastIter) stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    // Datapath: operand capture, one shift-add step per cycle, product latch
    always_ff @(posedge CC_ALUSEQ_CLOCK_50) begin
        if (CC_ALUSEQ_RESET_InHigh) begin
            hiReg                    <= '0;
            loReg                    <= '0;
            mReg                     <= '0;
            cnt                      <= '0;
            CC_ALUSEQ_product_OutBus <= '0;
            CC_ALUSEQ_busy_Out       <= 1'b0;
            CC_ALUSEQ_done_Out       <= 1'b0;
        end else begin
            CC_ALUSEQ_done_Out <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (zeroOp) begin
                            CC_ALUSEQ_product_OutBus <= '0;
                            CC_ALUSEQ_done_Out       <= 1'b1;
                        end else begin
                            mReg               <= CC_ALUSEQ_multiplicand_InBus;
                            loReg              <= CC_ALUSEQ_multiplier_InBus;
                            hiReg              <= '0;
                            cnt                <= '0;
                            CC_ALUSEQ_busy_Out <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (lastIter) begin
                        // {c, alu, LO} >> 1 lands directly in the product.
                        CC_ALUSEQ_product_OutBus <= {carryIn, CC_ALUSEQ_aluData_InBus, loReg[W-1:1]};
                        CC_ALUSEQ_done_Out       <= 1'b1;
                        CC_ALUSEQ_busy_Out       <= 1'b0;
                        hiReg                    <= '0;
                        loReg                    <= '0;
                        mReg                     <= '0;
                        cnt                      <= '0;
                    end else begin
                        hiReg <= {carryIn, CC_ALUSEQ_aluData_InBus[W-1:1]};
                        loReg <= {CC_ALUSEQ_aluData_InBus[0], loReg[W-1:1]};
                        cnt   <= cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
